// File: rtl/seq_mult32.sv
// Sequential 32x32 unsigned shift-add multiplier.
// One partial product per clock through a single prefix adder.

module Prefix_Add32_gen (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cIn,
    output logic [31:0] s,
    output logic        cOut
);

    logic [31:0] gAll;
    logic [31:0] pAll;
    logic [32:0] carry;

    // Kogge-Stone prefix tree, five levels of span 1,2,4,8,16
    for (genvar l = 0; l < 5; l++) begin : gLvl
        localparam int D = 1 << l;
        logic [31:0] gPrev;
        logic [31:0] pPrev;
        logic [31:0] gCur;
        logic [31:0] pCur;
        if (l == 0) begin : gFirst
            assign gPrev = x & y;
            assign pPrev = x ^ y;
        end else begin : gRest
            assign gPrev = gLvl[l-1].gCur;
            assign pPrev = gLvl[l-1].pCur;
        end
        assign gCur = gPrev | (pPrev & {gPrev[31-D:0], {D{1'b0}}});
        assign pCur = pPrev & {pPrev[31-D:0], {D{1'b1}}};
    end

    assign gAll  = gLvl[4].gCur;
    assign pAll  = gLvl[4].pCur;
    assign carry = {gAll | (pAll & {32{cIn}}), cIn};
    assign s     = x ^ y ^ carry[31:0];
    assign cOut  = carry[32];

endmodule

module seq_mult32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    if (WIDTH != 32) begin : gBadWidth
        $error("seq_mult32: WIDTH must be 32 to match Prefix_Add32_gen");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [5:0]           count;
    logic                 doneQ;
    logic [WIDTH-1:0]     addY;
    logic [WIDTH-1:0]     sum;
    logic                 sumCarry;
    logic [2*WIDTH-1:0]   accNext;
    logic                 lastStep;

    Prefix_Add32_gen uAdd (
        .x    (acc[2*WIDTH-1:WIDTH]),
        .y    (addY),
        .cIn  (1'b0),
        .s    (sum),
        .cOut (sumCarry)
    );

    assign addY     = acc[0] ? mcand : '0;
    // The adder's carry-out becomes the MSB of the right-shifted accumulator
    assign accNext  = {sumCarry, sum, acc[WIDTH-1:1]};
    assign lastStep = (count == 6'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (lastStep) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
            doneQ   <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        acc   <= {{WIDTH{1'b0}}, b};
                        count <= '0;
                    end
                end
                RUN: begin
                    acc   <= accNext;
                    count <= count + 6'd1;
                end
                DONE: begin
                    product <= acc;
                    doneQ   <= 1'b1;
                end
                default: begin
                    doneQ <= 1'b0;
                end
            endcase
        end
    end

    assign done = doneQ;

endmodule
